// File: rtl/updown_counter_ld.sv
// Modulo-MODULUS up/down counter with synchronous parallel load, enable and
// terminal-count output. q1 is a registered complement of q. Stages cascade
// by feeding tc into the next stage's en.
module updown_counter_ld #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rn,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q1,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_nxt;

  // Increment with wrap at the modulus rather than at 2**WIDTH.
  function automatic logic [WIDTH-1:0] inc_wrap(input logic [WIDTH-1:0] v);
    return (v == TOP) ? '0 : v + 1'b1;
  endfunction

  // Decrement with wrap from 0 back to the top legal state.
  function automatic logic [WIDTH-1:0] dec_wrap(input logic [WIDTH-1:0] v);
    return (v == '0) ? TOP : v - 1'b1;
  endfunction

  // Out-of-range load values clamp to 0 so q never leaves 0..MODULUS-1.
  function automatic logic [WIDTH-1:0] load_clamp(input logic [WIDTH-1:0] v);
    return ({1'b0, v} < MOD_X) ? v : '0;
  endfunction

  // Next-state selection: load has priority over count enable.
  always_comb begin
    q_nxt = q;
    if (ld)
      q_nxt = load_clamp(din);
    else if (en)
      q_nxt = up ? inc_wrap(q) : dec_wrap(q);
  end

  // State flops; q1 is registered alongside q so it tracks ~q through reset.
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      q  <= '0;
      q1 <= '1;
    end else begin
      q  <= q_nxt;
      q1 <= ~q_nxt;
    end
  end

  // High in the cycle whose next edge wraps the counter; suppressed by load.
  assign tc = en & ~ld & ((up & (q == TOP)) | (~up & (q == '0)));

endmodule

// File: tb/tb_updown_counter_ld.sv
// Directed bench for updown_counter_ld: reset, up/down wrap, clamped load,
// asynchronous reset mid-count, hold/direction change and a two-stage cascade.
module tb_updown_counter_ld;

  logic       clk = 1'b0;
  logic       rn  = 1'b1;
  logic       en  = 1'b0;
  logic       up  = 1'b1;
  logic       ld  = 1'b0;
  logic [3:0] din = 4'd0;
  logic [3:0] q, q1;
  logic       tc;

  // cascade pair
  logic       rn_c  = 1'b1;
  logic       en_c  = 1'b0;
  logic       one   = 1'b1;
  logic       zero  = 1'b0;
  logic [3:0] din_c = 4'd0;
  logic [3:0] u_q, u_q1, t_q, t_q1;
  logic       u_tc, t_tc;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  updown_counter_ld #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .rn(rn), .en(en), .up(up), .ld(ld), .din(din),
    .q(q), .q1(q1), .tc(tc)
  );

  updown_counter_ld #(.WIDTH(4), .MODULUS(10)) units (
    .clk(clk), .rn(rn_c), .en(en_c), .up(one), .ld(zero), .din(din_c),
    .q(u_q), .q1(u_q1), .tc(u_tc)
  );

  updown_counter_ld #(.WIDTH(4), .MODULUS(10)) tens (
    .clk(clk), .rn(rn_c), .en(u_tc), .up(one), .ld(zero), .din(din_c),
    .q(t_q), .q1(t_q1), .tc(t_tc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [3:0] v);
    ld = 1'b1; din = v; en = 1'b0;
    step();
    ld = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1; up = 1'b1; ld = 1'b0;
    #2 rn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (q !== 4'd0 || q1 !== 4'hF || tc !== 1'b0)
        $display("FAIL reset[%0d] q=%0d q1=%h tc=%b want q=0 q1=f tc=0", i, q, q1, tc);
      else passes++;
      step();
    end
    checks++;
    if (q !== 4'd0 || q1 !== 4'hF)
      $display("FAIL reset_hold q=%0d q1=%h want q=0 q1=f", q, q1);
    else passes++;
    #2 rn = 1'b1;
    step();
    checks++;
    if (q !== 4'd1 || q1 !== 4'hE)
      $display("FAIL reset_release q=%0d q1=%h want q=1 q1=e", q, q1);
    else passes++;
  endtask

  task automatic test_count_up();
    int   exp_q [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    logic exp_tc[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    load_val(4'd0);
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (tc !== exp_tc[i])
        $display("FAIL up_tc[%0d] got %b want %b (q=%0d)", i, tc, exp_tc[i], q);
      else passes++;
      step();
      checks++;
      if (q !== 4'(exp_q[i]) || q1 !== ~4'(exp_q[i]))
        $display("FAIL up_q[%0d] got %0d/%h want %0d", i, q, q1, exp_q[i]);
      else passes++;
    end
  endtask

  task automatic test_count_down();
    int   exp_q [5] = '{2, 1, 0, 9, 8};
    logic exp_tc[5] = '{0, 0, 0, 1, 0};
    load_val(4'd3);
    checks++;
    if (q !== 4'd3)
      $display("FAIL dn_load got %0d want 3", q);
    else passes++;
    en = 1'b1; up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tc !== exp_tc[i])
        $display("FAIL dn_tc[%0d] got %b want %b (q=%0d)", i, tc, exp_tc[i], q);
      else passes++;
      step();
      checks++;
      if (q !== 4'(exp_q[i]))
        $display("FAIL dn_q[%0d] got %0d want %0d", i, q, exp_q[i]);
      else passes++;
    end
  endtask

  task automatic test_illegal_load();
    load_val(4'd9);
    ld = 1'b1; din = 4'd12; en = 1'b1; up = 1'b1;
    #1;
    checks++;
    if (tc !== 1'b0)
      $display("FAIL ld_tc got %b want 0", tc);
    else passes++;
    step();
    ld = 1'b0; en = 1'b0;
    checks++;
    if (q !== 4'd0 || q1 !== 4'hF)
      $display("FAIL ld_clamp got %0d/%h want 0/f", q, q1);
    else passes++;
    load_val(4'd15);
    checks++;
    if (q !== 4'd0)
      $display("FAIL ld_clamp15 got %0d want 0", q);
    else passes++;
  endtask

  task automatic test_async_reset();
    load_val(4'd7);
    en = 1'b1; up = 1'b1;
    #2 rn = 1'b0;
    #1;
    checks++;
    if (q !== 4'd0 || q1 !== 4'hF)
      $display("FAIL async_rst got %0d/%h want 0/f", q, q1);
    else passes++;
    step();
    #2 rn = 1'b1;
    step();
    checks++;
    if (q !== 4'd1)
      $display("FAIL async_resume got %0d want 1", q);
    else passes++;
  endtask

  task automatic test_hold_dir();
    load_val(4'd5);
    en = 1'b0; up = 1'b1;
    step();
    checks++;
    if (q !== 4'd5)
      $display("FAIL hold got %0d want 5", q);
    else passes++;
    en = 1'b1;
    step();
    checks++;
    if (q !== 4'd6)
      $display("FAIL dir_up got %0d want 6", q);
    else passes++;
    up = 1'b0;
    step();
    checks++;
    if (q !== 4'd5)
      $display("FAIL dir_down got %0d want 5", q);
    else passes++;
    en = 1'b0;
  endtask

  task automatic test_cascade();
    en_c = 1'b0;
    #2 rn_c = 1'b0;
    #2 rn_c = 1'b1;
    en_c = 1'b1;
    for (int i = 0; i < 99; i++) step();
    checks++;
    if (t_q !== 4'd9 || u_q !== 4'd9)
      $display("FAIL cascade_99 got %0d%0d want 99", t_q, u_q);
    else passes++;
    checks++;
    if (u_tc !== 1'b1 || t_tc !== 1'b1)
      $display("FAIL cascade_tc got u=%b t=%b want 1 1", u_tc, t_tc);
    else passes++;
    step();
    checks++;
    if (t_q !== 4'd0 || u_q !== 4'd0)
      $display("FAIL cascade_wrap got %0d%0d want 00", t_q, u_q);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_illegal_load();
    test_async_reset();
    test_hold_dir();
    test_cascade();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
